// File: rtl/kdtree_input_router.sv
// kdtree_input_router: drains the input FIFO after load_kdtree and routes the
// word stream into internal-node, leaf and query-patch record writes.
// Optional build macro KDTREE_ROUTER_CHECK_EN: clamps out-of-range node split
// dimensions to PATCH_SIZE-1 and adds the sticky err_dim output.
module kdtree_input_router #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned PATCH_SIZE = 5,
  parameter int unsigned LEAF_SIZE  = 8,
  parameter int unsigned NUM_LEAVES = 64,
  parameter int unsigned NUM_QUERYS = 494
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    load_kdtree,
  input  logic [DATA_WIDTH-1:0]                   fifo_rdata,
  input  logic                                    fifo_rempty_n,
  output logic                                    fifo_deq,
  output logic                                    node_wen,
  output logic [$clog2(NUM_LEAVES-1)-1:0]         node_waddr,
  output logic [$clog2(PATCH_SIZE)-1:0]           node_wdim,
  output logic [DATA_WIDTH-1:0]                   node_wmedian,
  output logic                                    leaf_wen,
  output logic [$clog2(NUM_LEAVES)-1:0]           leaf_waddr,
  output logic [$clog2(LEAF_SIZE)-1:0]            leaf_wpatch,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]        leaf_wdata,
  output logic [DATA_WIDTH-1:0]                   leaf_widx,
  output logic                                    query_wen,
  output logic [$clog2(NUM_QUERYS)-1:0]           query_waddr,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]        query_wdata,
  output logic                                    busy,
  output logic                                    load_done
`ifdef KDTREE_ROUTER_CHECK_EN
  ,
  output logic                                    err_dim
`endif
);

  localparam int unsigned NA_W  = $clog2(NUM_LEAVES-1);
  localparam int unsigned WD_W  = $clog2(PATCH_SIZE);
  localparam int unsigned LA_W  = $clog2(NUM_LEAVES);
  localparam int unsigned LS_W  = $clog2(LEAF_SIZE);
  localparam int unsigned QA_W  = $clog2(NUM_QUERYS);
  localparam int unsigned REC_W = DATA_WIDTH*PATCH_SIZE;
  localparam int unsigned RC_W  = (LA_W+LS_W > QA_W) ? LA_W+LS_W : QA_W;
  localparam int unsigned WC_W  = $clog2(PATCH_SIZE+1);

  localparam logic [RC_W-1:0] NODE_LAST  = RC_W'(NUM_LEAVES-2);
  localparam logic [RC_W-1:0] LEAF_LAST  = RC_W'(NUM_LEAVES*LEAF_SIZE-1);
  localparam logic [RC_W-1:0] QUERY_LAST = RC_W'(NUM_QUERYS-1);
  localparam logic [WC_W-1:0] LEAF_IDX_WC  = WC_W'(PATCH_SIZE);
  localparam logic [WC_W-1:0] QUERY_END_WC = WC_W'(PATCH_SIZE-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NODES,
    S_LEAVES,
    S_QUERY,
    S_DONE
  } state_t;

  state_t              state;
  logic [WC_W-1:0]     wc;
  logic [RC_W-1:0]     rc;
  logic [REC_W-1:0]    asm_data;
  logic [WD_W-1:0]     dim_q;

  logic active;

  // Pop the FIFO head whenever a word is available in a loading state;
  // a start pulse takes priority and suppresses the pop.
  always_comb begin
    active    = (state == S_NODES) || (state == S_LEAVES) || (state == S_QUERY);
    fifo_deq  = fifo_rempty_n && active && !load_kdtree;
    busy      = active;
    load_done = (state == S_DONE);
  end

  // Sequencer, record assembly and registered write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wc           <= '0;
      rc           <= '0;
      asm_data     <= '0;
      dim_q        <= '0;
      node_wen     <= 1'b0;
      node_waddr   <= '0;
      node_wdim    <= '0;
      node_wmedian <= '0;
      leaf_wen     <= 1'b0;
      leaf_waddr   <= '0;
      leaf_wpatch  <= '0;
      leaf_wdata   <= '0;
      leaf_widx    <= '0;
      query_wen    <= 1'b0;
      query_waddr  <= '0;
      query_wdata  <= '0;
`ifdef KDTREE_ROUTER_CHECK_EN
      err_dim      <= 1'b0;
`endif
    end else begin
      node_wen  <= 1'b0;
      leaf_wen  <= 1'b0;
      query_wen <= 1'b0;
      if (load_kdtree) begin
        state    <= S_NODES;
        wc       <= '0;
        rc       <= '0;
        asm_data <= '0;
        dim_q    <= '0;
`ifdef KDTREE_ROUTER_CHECK_EN
        err_dim  <= 1'b0;
`endif
      end else if (fifo_deq) begin
        case (state)
          S_NODES: begin
            if (wc == '0) begin
`ifdef KDTREE_ROUTER_CHECK_EN
              if (fifo_rdata >= DATA_WIDTH'(PATCH_SIZE)) begin
                dim_q   <= WD_W'(PATCH_SIZE-1);
                err_dim <= 1'b1;
              end else begin
                dim_q <= fifo_rdata[WD_W-1:0];
              end
`else
              dim_q <= fifo_rdata[WD_W-1:0];
`endif
              wc <= WC_W'(1);
            end else begin
              node_wen     <= 1'b1;
              node_waddr   <= rc[NA_W-1:0];
              node_wdim    <= dim_q;
              node_wmedian <= fifo_rdata;
              wc           <= '0;
              if (rc == NODE_LAST) begin
                rc    <= '0;
                state <= S_LEAVES;
              end else begin
                rc <= rc + RC_W'(1);
              end
            end
          end
          S_LEAVES: begin
            if (wc == LEAF_IDX_WC) begin
              leaf_wen    <= 1'b1;
              leaf_waddr  <= rc[LS_W +: LA_W];
              leaf_wpatch <= rc[LS_W-1:0];
              leaf_wdata  <= asm_data;
              leaf_widx   <= fifo_rdata;
              wc          <= '0;
              if (rc == LEAF_LAST) begin
                rc    <= '0;
                state <= S_QUERY;
              end else begin
                rc <= rc + RC_W'(1);
              end
            end else begin
              for (int unsigned k = 0; k < PATCH_SIZE; k++)
                if (wc == WC_W'(k)) asm_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
              wc <= wc + WC_W'(1);
            end
          end
          S_QUERY: begin
            if (wc == QUERY_END_WC) begin
              query_wen   <= 1'b1;
              query_waddr <= rc[QA_W-1:0];
              // Last word bypasses the assembly register straight into the top field.
              query_wdata <= {fifo_rdata, asm_data[REC_W-DATA_WIDTH-1:0]};
              wc          <= '0;
              if (rc == QUERY_LAST) begin
                rc    <= '0;
                state <= S_DONE;
              end else begin
                rc <= rc + RC_W'(1);
              end
            end else begin
              for (int unsigned k = 0; k < PATCH_SIZE; k++)
                if (wc == WC_W'(k)) asm_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
              wc <= wc + WC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kdtree_input_router.sv
// Testbench for kdtree_input_router: directed scenarios against a FIFO model
// and hand-computed record contents.
module tb_kdtree_input_router;

  localparam int N_NODE_W  = 126;
  localparam int N_LEAF_W  = 3072;
  localparam int N_WORDS   = 5668;
  localparam int N_NODES   = 63;
  localparam int N_LEAFREC = 512;
  localparam int N_QUERY   = 494;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_kdtree = 1'b0;
  logic [10:0] fifo_rdata = '0;
  logic        fifo_rempty_n = 1'b0;
  logic        fifo_deq;
  logic        node_wen;
  logic [5:0]  node_waddr;
  logic [2:0]  node_wdim;
  logic [10:0] node_wmedian;
  logic        leaf_wen;
  logic [5:0]  leaf_waddr;
  logic [2:0]  leaf_wpatch;
  logic [54:0] leaf_wdata;
  logic [10:0] leaf_widx;
  logic        query_wen;
  logic [8:0]  query_waddr;
  logic [54:0] query_wdata;
  logic        busy;
  logic        load_done;
`ifdef KDTREE_ROUTER_CHECK_EN
  logic        err_dim;
`endif

  kdtree_input_router dut (
    .clk(clk), .rst_n(rst_n), .load_kdtree(load_kdtree),
    .fifo_rdata(fifo_rdata), .fifo_rempty_n(fifo_rempty_n), .fifo_deq(fifo_deq),
    .node_wen(node_wen), .node_waddr(node_waddr), .node_wdim(node_wdim),
    .node_wmedian(node_wmedian),
    .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_wpatch(leaf_wpatch),
    .leaf_wdata(leaf_wdata), .leaf_widx(leaf_widx),
    .query_wen(query_wen), .query_waddr(query_waddr), .query_wdata(query_wdata),
    .busy(busy), .load_done(load_done)
`ifdef KDTREE_ROUTER_CHECK_EN
    , .err_dim(err_dim)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   ptr = 0;
  logic deq_q = 1'b0;
  int   viol = 0;
  bit   timed_out = 1'b0;
  logic ld_prev = 1'b0, ld_cur = 1'b0;

  int          n_node = 0, n_leaf = 0, n_query = 0;
  logic [5:0]  cap_node_addr [0:63];
  logic [2:0]  cap_node_dim  [0:63];
  logic [10:0] cap_node_med  [0:63];
  logic [5:0]  cap_leaf_addr [0:511];
  logic [2:0]  cap_leaf_slot [0:511];
  logic [54:0] cap_leaf_data [0:511];
  logic [10:0] cap_leaf_idx  [0:511];
  logic [8:0]  cap_q_addr    [0:493];
  logic [54:0] cap_q_data    [0:493];

  // FIFO model: a pop happens on each edge where fifo_deq was high
  always @(posedge clk) deq_q <= fifo_deq;
  always @(posedge clk) if (fifo_deq === 1'b1 && fifo_rempty_n !== 1'b1) viol <= viol + 1;

  // Stream word generator; embeds the directed node-0 and leaf-1/slot-0 records
  function automatic logic [10:0] gen(input int i);
    if (i == 0) return 11'd2;
    if (i == 1) return 11'd300;
    if (i < N_NODE_W) return (i % 2 == 0) ? 11'((i/2) % 5) : 11'((i*37 + 11) % 2048);
    if (i >= 174 && i <= 178) return 11'(i - 173);
    if (i == 179) return 11'd77;
    return 11'((i*13 + 5) % 2048);
  endfunction

  task automatic start_load();
    ptr = 0; n_node = 0; n_leaf = 0; n_query = 0;
    @(negedge clk);
    fifo_rempty_n = 1'b0;
    load_kdtree = 1'b1;
    @(negedge clk);
    load_kdtree = 1'b0;
  endtask

  // Drive the stream from the current negedge until 'upto' words have popped
  task automatic stream(input int upto, input bit gaps);
    int  cyc;
    int  budget;
    bit  v;
    cyc = 0;
    budget = upto*4 + 200;
    timed_out = 1'b0;
    forever begin
      if (deq_q) ptr++;
      if (node_wen) begin
        if (n_node < 64) begin
          cap_node_addr[n_node] = node_waddr;
          cap_node_dim[n_node]  = node_wdim;
          cap_node_med[n_node]  = node_wmedian;
        end
        n_node++;
      end
      if (leaf_wen) begin
        if (n_leaf < 512) begin
          cap_leaf_addr[n_leaf] = leaf_waddr;
          cap_leaf_slot[n_leaf] = leaf_wpatch;
          cap_leaf_data[n_leaf] = leaf_wdata;
          cap_leaf_idx[n_leaf]  = leaf_widx;
        end
        n_leaf++;
      end
      if (query_wen) begin
        if (n_query < 494) begin
          cap_q_addr[n_query] = query_waddr;
          cap_q_data[n_query] = query_wdata;
        end
        n_query++;
      end
      ld_prev = ld_cur;
      ld_cur  = load_done;
      if (ptr >= upto) begin
        fifo_rempty_n = 1'b0;
        return;
      end
      if (cyc >= budget) begin
        timed_out = 1'b1;
        fifo_rempty_n = 1'b0;
        return;
      end
      v = gaps ? ($urandom % 2 == 1) : 1'b1;
      fifo_rempty_n = v;
      fifo_rdata = v ? gen(ptr) : 11'h7ff;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fifo_rempty_n = 1'b1;
    fifo_rdata = 11'h123;
    load_kdtree = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fifo_deq !== 1'b0) begin errors++; $display("FAIL reset_deq: got %b expected 0", fifo_deq); end
    checks++; if ({node_wen, leaf_wen, query_wen} !== 3'b000) begin errors++; $display("FAIL reset_wen: got %b expected 000", {node_wen, leaf_wen, query_wen}); end
    checks++; if ({busy, load_done} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b expected 00", {busy, load_done}); end
    checks++; if ({node_waddr, node_wdim, node_wmedian} !== 20'd0) begin errors++; $display("FAIL reset_node: got %h expected 0", {node_waddr, node_wdim, node_wmedian}); end
    checks++; if ({leaf_waddr, leaf_wpatch, leaf_wdata, leaf_widx} !== 75'd0) begin errors++; $display("FAIL reset_leaf: got %h expected 0", {leaf_waddr, leaf_wpatch, leaf_wdata, leaf_widx}); end
    checks++; if ({query_waddr, query_wdata} !== 64'd0) begin errors++; $display("FAIL reset_query: got %h expected 0", {query_waddr, query_wdata}); end
`ifdef KDTREE_ROUTER_CHECK_EN
    checks++; if (err_dim !== 1'b0) begin errors++; $display("FAIL reset_err_dim: got %b expected 0", err_dim); end
`endif
    fifo_rempty_n = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_node_pair();
    start_load();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", busy); end
    fifo_rdata = 11'd2; fifo_rempty_n = 1'b1;
    #1;
    checks++; if (fifo_deq !== 1'b1) begin errors++; $display("FAIL node_deq: got %b expected 1", fifo_deq); end
    @(negedge clk);
    fifo_rdata = 11'd300;
    checks++; if (node_wen !== 1'b0) begin errors++; $display("FAIL node_early_wen: got %b expected 0", node_wen); end
    @(negedge clk);
    fifo_rempty_n = 1'b0;
    checks++; if (node_wen !== 1'b1) begin errors++; $display("FAIL node_wen: got %b expected 1", node_wen); end
    checks++; if ({node_waddr, node_wdim, node_wmedian} !== {6'd0, 3'd2, 11'd300}) begin errors++; $display("FAIL node_pair: got addr %0d dim %0d med %0d expected 0 2 300", node_waddr, node_wdim, node_wmedian); end
    @(negedge clk);
    checks++; if (node_wen !== 1'b0 || node_wmedian !== 11'd300) begin errors++; $display("FAIL node_hold: got wen %b med %0d expected 0 300", node_wen, node_wmedian); end
  endtask

  task automatic test_leaf_record();
    start_load();
    stream(180, 1'b0);
    checks++; if (timed_out || n_leaf !== 9) begin errors++; $display("FAIL leaf_count: got %0d expected 9", n_leaf); end
    if (n_leaf >= 9) begin
      checks++;
      if (cap_leaf_addr[8] !== 6'd1 || cap_leaf_slot[8] !== 3'd0 || cap_leaf_data[8] !== {11'd5, 11'd4, 11'd3, 11'd2, 11'd1} || cap_leaf_idx[8] !== 11'd77) begin
        errors++;
        $display("FAIL leaf_record: got addr %0d slot %0d data %h idx %0d expected 1 0 %h 77",
                 cap_leaf_addr[8], cap_leaf_slot[8], cap_leaf_data[8], cap_leaf_idx[8], {11'd5, 11'd4, 11'd3, 11'd2, 11'd1});
      end
    end
  endtask

  task automatic test_full_stream(input bit gaps);
    logic [10:0] w0, w1;
    logic [54:0] exp_d;
    start_load();
    stream(N_WORDS, gaps);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL stream_timeout gaps=%0d: got %0d words expected %0d", gaps, ptr, N_WORDS); end
    checks++; if (n_node !== N_NODES) begin errors++; $display("FAIL node_count gaps=%0d: got %0d expected %0d", gaps, n_node, N_NODES); end
    checks++; if (n_leaf !== N_LEAFREC) begin errors++; $display("FAIL leaf_count gaps=%0d: got %0d expected %0d", gaps, n_leaf, N_LEAFREC); end
    checks++; if (n_query !== N_QUERY) begin errors++; $display("FAIL query_count gaps=%0d: got %0d expected %0d", gaps, n_query, N_QUERY); end
    checks++; if (ld_cur !== 1'b1 || ld_prev !== 1'b0) begin errors++; $display("FAIL load_done_timing gaps=%0d: got %b%b expected 01", gaps, ld_prev, ld_cur); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy gaps=%0d: got %b expected 0", gaps, busy); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL deq_while_empty gaps=%0d: got %0d expected 0", gaps, viol); end
    for (int n = 0; n < N_NODES && n < n_node; n++) begin
      w0 = gen(2*n); w1 = gen(2*n + 1);
      checks++;
      if (cap_node_addr[n] !== 6'(n) || cap_node_dim[n] !== w0[2:0] || cap_node_med[n] !== w1) begin
        errors++;
        $display("FAIL node_rec %0d gaps=%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", n, gaps,
                 cap_node_addr[n], cap_node_dim[n], cap_node_med[n], n, w0[2:0], w1);
      end
    end
    for (int r = 0; r < N_LEAFREC && r < n_leaf; r++) begin
      for (int k = 0; k < 5; k++) exp_d[k*11 +: 11] = gen(N_NODE_W + 6*r + k);
      w1 = gen(N_NODE_W + 6*r + 5);
      checks++;
      if (cap_leaf_addr[r] !== 6'(r/8) || cap_leaf_slot[r] !== 3'(r%8) || cap_leaf_data[r] !== exp_d || cap_leaf_idx[r] !== w1) begin
        errors++;
        $display("FAIL leaf_rec %0d gaps=%0d: got %0d/%0d/%h/%0d expected %0d/%0d/%h/%0d", r, gaps,
                 cap_leaf_addr[r], cap_leaf_slot[r], cap_leaf_data[r], cap_leaf_idx[r], r/8, r%8, exp_d, w1);
      end
    end
    for (int q = 0; q < N_QUERY && q < n_query; q++) begin
      for (int k = 0; k < 5; k++) exp_d[k*11 +: 11] = gen(N_NODE_W + N_LEAF_W + 5*q + k);
      checks++;
      if (cap_q_addr[q] !== 9'(q) || cap_q_data[q] !== exp_d) begin
        errors++;
        $display("FAIL query_rec %0d gaps=%0d: got %0d/%h expected %0d/%h", q, gaps, cap_q_addr[q], cap_q_data[q], q, exp_d);
      end
    end
  endtask

  task automatic test_abort();
    start_load();
    stream(N_NODE_W + 3, 1'b0);
    checks++; if (busy !== 1'b1 || n_leaf !== 0) begin errors++; $display("FAIL abort_pre: got busy %b leaves %0d expected 1 0", busy, n_leaf); end
    load_kdtree = 1'b1;
    fifo_rempty_n = 1'b1;
    fifo_rdata = 11'd9;
    #1;
    checks++; if (fifo_deq !== 1'b0) begin errors++; $display("FAIL abort_deq: got %b expected 0", fifo_deq); end
    @(negedge clk);
    load_kdtree = 1'b0;
    fifo_rdata = 11'd4;
    @(negedge clk);
    fifo_rdata = 11'd1000;
    @(negedge clk);
    fifo_rempty_n = 1'b0;
    checks++; if (node_wen !== 1'b1 || leaf_wen !== 1'b0) begin errors++; $display("FAIL abort_wen: got node %b leaf %b expected 1 0", node_wen, leaf_wen); end
    checks++; if ({node_waddr, node_wdim, node_wmedian} !== {6'd0, 3'd4, 11'd1000}) begin errors++; $display("FAIL abort_node: got %0d/%0d/%0d expected 0/4/1000", node_waddr, node_wdim, node_wmedian); end
    fifo_rdata = 11'd3;
    fifo_rempty_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, fifo_deq, node_wen, node_wmedian} !== 14'd0) begin errors++; $display("FAIL midload_reset: got %h expected 0", {busy, fifo_deq, node_wen, node_wmedian}); end
    fifo_rempty_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef KDTREE_ROUTER_CHECK_EN
  task automatic test_dim_check();
    start_load();
    fifo_rdata = 11'd7; fifo_rempty_n = 1'b1;
    @(negedge clk);
    fifo_rdata = 11'd10;
    @(negedge clk);
    fifo_rempty_n = 1'b0;
    checks++; if (node_wen !== 1'b1 || node_wdim !== 3'd4) begin errors++; $display("FAIL dim_clamp: got wen %b dim %0d expected 1 4", node_wen, node_wdim); end
    @(negedge clk);
    checks++; if (err_dim !== 1'b1) begin errors++; $display("FAIL err_dim_sticky: got %b expected 1", err_dim); end
    start_load();
    checks++; if (err_dim !== 1'b0) begin errors++; $display("FAIL err_dim_clear: got %b expected 0", err_dim); end
  endtask
`endif

  initial begin
    test_reset();
    test_node_pair();
    test_leaf_record();
    test_full_stream(1'b0);
    test_full_stream(1'b1);
    test_abort();
`ifdef KDTREE_ROUTER_CHECK_EN
    test_dim_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
